// File: rtl/dmux16_router.sv
`default_nettype none
// ============================================================================
// Module      : dmux16_router
// Description : Routes 16-bit words from one valid/ready input to one of two
//               back-pressured output channels, each with a 2-entry FIFO and
//               a delivered-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux16_router #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] a_data,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [15:0] b_data,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [15:0] a_count,
    output logic [15:0] b_count
);

    localparam logic [1:0] c_full_occ = 2'(DEPTH);

    logic [1:0]  w_full;
    logic [1:0]  w_valid;
    logic [1:0]  w_push;
    logic [1:0]  w_pop;
    logic [1:0]  w_ready_out;
    logic [15:0] w_head  [2];
    logic [15:0] w_count [2];

    // Ready looks only at the selected FIFO, so a full FIFO never blocks the other
    assign in_ready = !rst && (in_sel ? !w_full[1] : !w_full[0]);

    assign w_push[0]      = in_valid && in_ready && !in_sel;
    assign w_push[1]      = in_valid && in_ready &&  in_sel;
    assign w_ready_out[0] = a_ready;
    assign w_ready_out[1] = b_ready;
    assign w_pop          = w_valid & w_ready_out;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [15:0] r_mem [DEPTH];
        logic        r_wptr;
        logic        r_rptr;
        logic [1:0]  r_occ;
        logic [15:0] r_count;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_mem[0] <= 16'h0000;
                r_mem[1] <= 16'h0000;
                r_wptr   <= 1'b0;
                r_rptr   <= 1'b0;
                r_occ    <= 2'd0;
                r_count  <= 16'h0000;
            end else begin
                if (w_push[g]) begin
                    r_mem[r_wptr] <= in_data;
                    r_wptr        <= ~r_wptr;
                end
                if (w_pop[g]) begin
                    r_rptr  <= ~r_rptr;
                    r_count <= r_count + 16'd1;
                end
                case ({w_push[g], w_pop[g]})
                    2'b10:   r_occ <= r_occ + 2'd1;
                    2'b01:   r_occ <= r_occ - 2'd1;
                    default: r_occ <= r_occ;
                endcase
            end
        end

        assign w_full[g]  = (r_occ == c_full_occ);
        assign w_valid[g] = (r_occ != 2'd0);
        // Empty FIFO presents zero rather than a stale entry
        assign w_head[g]  = w_valid[g] ? r_mem[r_rptr] : 16'h0000;
        assign w_count[g] = r_count;
    end

    assign a_valid = w_valid[0];
    assign b_valid = w_valid[1];
    assign a_data  = w_head[0];
    assign b_data  = w_head[1];
    assign a_count = w_count[0];
    assign b_count = w_count[1];

endmodule
`default_nettype wire

// File: tb/tb_dmux16_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux16_router
// Description : Scoreboard bench for dmux16_router; per-channel expected-word
//               queues and counter models checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux16_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = 16'h0;
    logic        in_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_data, b_data, a_count, b_count;
    logic        a_valid, b_valid;
    logic        a_ready = 1'b0;
    logic        b_ready = 1'b0;

    always #5 clk = ~clk;

    dmux16_router dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_acnt = 16'h0;
    logic [15:0] exp_bcnt = 16'h0;
    logic        mon_en = 1'b0;
    logic        m_rdy;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor on the falling edge: compare, then advance the model for the next rising edge
    always @(negedge clk) begin
        if (mon_en) begin
            m_rdy = !rst && (in_sel ? (qb.size() < 2) : (qa.size() < 2));
            check("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
            check("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
            check("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
            check("a_data", {16'd0, a_data}, {16'd0, (qa.size() != 0) ? qa[0] : 16'h0});
            check("b_data", {16'd0, b_data}, {16'd0, (qb.size() != 0) ? qb[0] : 16'h0});
            check("a_count", {16'd0, a_count}, {16'd0, exp_acnt});
            check("b_count", {16'd0, b_count}, {16'd0, exp_bcnt});
            if (!rst) begin
                if (a_ready && qa.size() != 0) begin
                    void'(qa.pop_front());
                    exp_acnt = exp_acnt + 16'd1;
                end
                if (b_ready && qb.size() != 0) begin
                    void'(qb.pop_front());
                    exp_bcnt = exp_bcnt + 16'd1;
                end
                if (in_valid && m_rdy) begin
                    if (in_sel) qb.push_back(in_data);
                    else        qa.push_back(in_data);
                end
            end
        end
    end

    task automatic push(input logic [15:0] d, input logic s);
        int k = 0;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int guard;
        logic [15:0] saved_b;

        // Reset state
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("rst_a_data", {16'd0, a_data}, 32'h0);
        check("rst_b_count", {16'd0, b_count}, 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic routing and one-cycle latency
        a_ready = 1'b1;
        b_ready = 1'b1;
        push(16'hAAAA, 1'b0);
        check("basic_a_valid", {31'd0, a_valid}, 32'd1);
        check("basic_a_data", {16'd0, a_data}, 32'hAAAA);
        push(16'h5555, 1'b1);
        check("basic_b_data", {16'd0, b_data}, 32'h5555);
        check("basic_a_gone", {31'd0, a_valid}, 32'd0);
        idle(2);
        check("basic_a_count", {16'd0, a_count}, 32'd1);
        check("basic_b_count", {16'd0, b_count}, 32'd1);

        // Back-pressure on a, b stays open
        a_ready = 1'b0;
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        in_sel = 1'b0;
        #1;
        check("full_a_ready", {31'd0, in_ready}, 32'd0);
        in_sel = 1'b1;
        #1;
        check("full_b_ready", {31'd0, in_ready}, 32'd1);
        push(16'hFFFF, 1'b1);
        check("full_b_data", {16'd0, b_data}, 32'hFFFF);

        // Hold stability while a is stalled
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_a_data", {16'd0, a_data}, 32'h0001);
            check("hold_a_count", {16'd0, a_count}, 32'd1);
        end
        @(posedge clk);
        #1;
        a_ready = 1'b1;
        idle(4);
        check("drain_a_count", {16'd0, a_count}, 32'd3);
        check("drain_b_count", {16'd0, b_count}, 32'd2);

        // Simultaneous push and pop on a one-entry FIFO
        a_ready = 1'b0;
        push(16'h0009, 1'b0);
        a_ready = 1'b1;
        push(16'h1234, 1'b0);
        check("sim_a_valid", {31'd0, a_valid}, 32'd1);
        check("sim_a_data", {16'd0, a_data}, 32'h1234);
        check("sim_a_count", {16'd0, a_count}, 32'd4);
        idle(2);

        // Counter wrap on b: 65536 deliveries return b_count to its start value
        saved_b  = b_count;
        acc      = 0;
        guard    = 0;
        in_sel   = 1'b1;
        in_data  = 16'h0;
        in_valid = 1'b1;
        while (acc < 65536 && guard < 70000) begin
            @(negedge clk);
            if (in_ready) acc++;
            guard++;
            @(posedge clk);
            #1;
            in_data = in_data + 16'd1;
            if (acc == 65536) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        if (acc < 65536) check("wrap_timeout", 32'd0, 32'd1);
        idle(3);
        check("wrap_b_count", {16'd0, b_count}, {16'd0, saved_b});
        check("wrap_a_count", {16'd0, a_count}, 32'd5);

        // Asynchronous reset mid-stream with both FIFOs loaded
        a_ready = 1'b0;
        b_ready = 1'b0;
        push(16'h0A0A, 1'b0);
        push(16'h0B0B, 1'b1);
        #2;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        exp_acnt = 16'h0;
        exp_bcnt = 16'h0;
        #1;
        check("arst_a_valid", {31'd0, a_valid}, 32'd0);
        check("arst_b_valid", {31'd0, b_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_a_count", {16'd0, a_count}, 32'd0);
        check("arst_b_count", {16'd0, b_count}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(16'h0000, 1'b0);
        check("post_a_valid", {31'd0, a_valid}, 32'd1);
        check("post_a_data", {16'd0, a_data}, 32'h0);
        check("post_b_valid", {31'd0, b_valid}, 32'd0);
        idle(2);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
